// File: rtl/counter_gray_updn.sv
`default_nettype none
// ============================================================================
// Module   : counter_gray_updn
// Purpose  : Up/down Gray counter, registered Gray output (CDC safe); optional
//            self-check output chk_err enabled by macro COUNTER_GRAY_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter_gray_updn #(
    parameter int               WIDTH     = 8,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             ld,
    input  logic             ld_is_gray,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_q,
    output logic             tc,
    output logic             wrap
`ifdef COUNTER_GRAY_CHK_EN
    ,
    output logic             chk_err
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic             at_end;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    assign at_end = up ? (bin_q == ALL_ONES) : (bin_q == '0);
    assign tc     = en & at_end;

    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (clr) begin
            bin_next = '0;
        end else if (ld) begin
            bin_next = ld_is_gray ? g2b(ld_val) : ld_val;
        end else if (en) begin
            if (at_end) begin
                wrap_next = 1'b1;
                if (SATURATE == 0) begin
                    bin_next = up ? '0 : ALL_ONES;
                end
            end else begin
                bin_next = up ? (bin_q + 1'b1) : (bin_q - 1'b1);
            end
        end
    end

    // Gray is registered from the next binary value, never decoded from bin_q.
    assign gray_next = bin_next ^ (bin_next >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RESET_VAL;
            gray_q <= RESET_GRAY;
            wrap   <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            wrap   <= wrap_next;
        end
    end

`ifdef COUNTER_GRAY_CHK_EN
    logic             count_step;
    logic             step_d;
    logic [WIDTH-1:0] gray_prev;
    logic             chk_hit;

    assign count_step = en & ~clr & ~ld & ~((SATURATE != 0) & at_end);
    // step_d flags that the last edge was a count step, so gray_q vs gray_prev must differ in one bit.
    assign chk_hit = (g2b(gray_q) != bin_q) |
                     (step_d & ($countones(gray_q ^ gray_prev) != 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err   <= 1'b0;
            step_d    <= 1'b0;
            gray_prev <= RESET_GRAY;
        end else begin
            step_d    <= count_step;
            gray_prev <= gray_q;
            chk_err   <= clr ? 1'b0 : (chk_err | chk_hit);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_gray_updn.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_gray_updn
// Purpose  : Scoreboard bench: wrapping (a) and saturating RESET_VAL=3 (b) counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_gray_updn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, en_a, up_a, clr_a, ld_a, ldg_a;
    logic [3:0] val_a, gray_a, bin_a;
    logic       tc_a, wrap_a;
    logic       rst_n_b, en_b, up_b, clr_b, ld_b, ldg_b;
    logic [3:0] val_b, gray_b, bin_b;
    logic       tc_b, wrap_b;
`ifdef COUNTER_GRAY_CHK_EN
    logic       chk_a, chk_b;
`endif

    counter_gray_updn #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'd0)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .up(up_a), .clr(clr_a), .ld(ld_a),
        .ld_is_gray(ldg_a), .ld_val(val_a), .gray_q(gray_a), .bin_q(bin_a),
        .tc(tc_a), .wrap(wrap_a)
`ifdef COUNTER_GRAY_CHK_EN
        , .chk_err(chk_a)
`endif
    );

    counter_gray_updn #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'd3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .up(up_b), .clr(clr_b), .ld(ld_b),
        .ld_is_gray(ldg_b), .ld_val(val_b), .gray_q(gray_b), .bin_q(bin_b),
        .tc(tc_b), .wrap(wrap_b)
`ifdef COUNTER_GRAY_CHK_EN
        , .chk_err(chk_b)
`endif
    );

    typedef struct {
        int         inst;
        string      name;
        logic       tc;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   pending = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    // Gray code of 0..15, written out by hand.
    logic [3:0] GRAY_TAB [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int inst, input logic en, input logic up, input logic clr,
                        input logic ld, input logic ldg, input logic [3:0] val,
                        input logic etc, input logic [3:0] ebin, input logic [3:0] egray,
                        input logic ewrap, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (inst == 0) begin
            en_a = en; up_a = up; clr_a = clr; ld_a = ld; ldg_a = ldg; val_a = val;
        end else begin
            en_b = en; up_b = up; clr_b = clr; ld_b = ld; ldg_b = ldg; val_b = val;
        end
        e = '{inst, name, etc, ebin, egray, ewrap};
        sb.push_back(e);
        pending++;
    endtask

    task automatic drain();
        int t = 0;
        while (pending != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #3;
        check("drain_pending", pending, 0);
    endtask

    // Monitor: tc is checked mid-cycle with the stimulus applied, the registered
    // results just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".tc"}, (e.inst == 0) ? tc_a : tc_b, e.tc);
                @(posedge clk);
                #2;
                check({e.name, ".bin"},  (e.inst == 0) ? bin_a  : bin_b,  e.bin);
                check({e.name, ".gray"}, (e.inst == 0) ? gray_a : gray_b, e.gray);
                check({e.name, ".wrap"}, (e.inst == 0) ? wrap_a : wrap_b, e.wrap);
                pending--;
            end
        end
    end

    initial begin
        rst_n_a = 0; en_a = 0; up_a = 0; clr_a = 0; ld_a = 0; ldg_a = 0; val_a = 0;
        rst_n_b = 0; en_b = 0; up_b = 0; clr_b = 0; ld_b = 0; ldg_b = 0; val_b = 0;
        #12;
        check("rst_a.bin", bin_a, 0);
        check("rst_a.gray", gray_a, 0);
        check("rst_a.wrap", wrap_a, 0);
        check("rst_a.tc", tc_a, 0);
        check("rst_b.bin", bin_b, 3);
        check("rst_b.gray", gray_b, 2);
        check("rst_b.wrap", wrap_b, 0);
        @(negedge clk);
        rst_n_a = 1; rst_n_b = 1;

        // Wrapping counter: full up lap, then down through the wrap and a reversal at 5.
        for (int k = 0; k < 16; k++)
            step(0, 1, 1, 0, 0, 0, 4'h0, (k == 15), 4'((k + 1) % 16),
                 GRAY_TAB[(k + 1) % 16], (k == 15), "up_lap");
        step(0, 0, 1, 0, 0, 0, 4'h0, 0, 4'd0, 4'h0, 0, "hold0");
        step(0, 1, 0, 0, 0, 0, 4'h0, 1, 4'd15, 4'b1000, 1, "dn_wrap");
        for (int b = 15; b > 5; b--)
            step(0, 1, 0, 0, 0, 0, 4'h0, 0, 4'(b - 1), GRAY_TAB[b - 1], 0, "dn");
        step(0, 1, 1, 0, 0, 0, 4'h0, 0, 4'd6, 4'b0101, 0, "rev_up");
        step(0, 1, 0, 0, 0, 0, 4'h0, 0, 4'd5, 4'b0111, 0, "rev_dn");
        step(0, 1, 0, 0, 0, 0, 4'h0, 0, 4'd4, 4'b0110, 0, "rev_dn2");
        step(0, 1, 0, 1, 0, 0, 4'h0, 0, 4'd0, 4'b0000, 0, "clr");
        step(0, 1, 1, 0, 1, 1, 4'b1101, 0, 4'd9, 4'b1101, 0, "ld_gray_en");
        step(0, 1, 1, 1, 1, 1, 4'b1101, 0, 4'd0, 4'b0000, 0, "clr_over_ld");
        step(0, 1, 1, 0, 1, 0, 4'd15, 0, 4'd15, 4'b1000, 0, "ld_bin15");
        step(0, 1, 1, 0, 0, 0, 4'h0, 1, 4'd0, 4'b0000, 1, "up_wrap");
        step(0, 0, 1, 0, 0, 0, 4'h0, 0, 4'd0, 4'b0000, 0, "hold_a");

        // Saturating counter.
        step(1, 0, 1, 0, 1, 0, 4'd14, 0, 4'd14, 4'b1001, 0, "b_ld14");
        step(1, 1, 1, 0, 0, 0, 4'h0, 0, 4'd15, 4'b1000, 0, "b_up1");
        step(1, 1, 1, 0, 0, 0, 4'h0, 1, 4'd15, 4'b1000, 1, "b_sat2");
        step(1, 1, 1, 0, 0, 0, 4'h0, 1, 4'd15, 4'b1000, 1, "b_sat3");
        step(1, 1, 0, 0, 0, 0, 4'h0, 0, 4'd14, 4'b1001, 0, "b_dn");
        step(1, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 4'b0000, 0, "b_ld0");
        step(1, 1, 0, 0, 0, 0, 4'h0, 1, 4'd0, 4'b0000, 1, "b_sat_lo");
        step(1, 0, 0, 0, 1, 0, 4'd7, 0, 4'd7, 4'b0100, 0, "b_ld7");
        step(1, 0, 0, 0, 0, 0, 4'h0, 0, 4'd7, 4'b0100, 0, "b_hold7");
        drain();

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n_b = 0;
        #1;
        check("async_rst.bin", bin_b, 3);
        check("async_rst.gray", gray_b, 2);
        check("async_rst.wrap", wrap_b, 0);
        @(negedge clk);
        rst_n_b = 1;

`ifdef COUNTER_GRAY_CHK_EN
        begin
            logic [3:0] g;
            for (int i = 0; i < 10000; i++) begin
                @(posedge clk);
                #1;
                en_a  = 1'($urandom_range(0, 1));
                up_a  = 1'($urandom_range(0, 1));
                clr_a = ($urandom_range(0, 49) == 0);
                ld_a  = ($urandom_range(0, 19) == 0);
                ldg_a = 1'($urandom_range(0, 1));
                val_a = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
            en_a = 0; clr_a = 0; ld_a = 0;
            @(posedge clk);
            #1;
            check("chk_random", chk_a, 0);
            g = gray_a;
            force dut_a.gray_q = g ^ 4'b0001;
            @(posedge clk);
            #1;
            release dut_a.gray_q;
            repeat (2) @(posedge clk);
            #1;
            check("chk_sticky", chk_a, 1);
            clr_a = 1;
            @(posedge clk);
            #1;
            clr_a = 0;
            check("chk_clr", chk_a, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
